stream_pair_scheduler: RTL and testbench
========================================

Name: stream_pair_scheduler

Overview:
- Packet-granular round-robin scheduler that merges two AXI-Stream inputs onto one registered output stream.
- Each grant lasts exactly PACKET_SIZE accepted beats; grants alternate when both inputs request.
- Counts granted packets and output beats per frame, and pulses a flag at every frame boundary.
- Sits between the two capture streams and the single downstream packet/frame consumer.

Parameters:
- DW, 128, data width of all streams.
- PACKET_SIZE, 2, beats per grant; must be ≥1.
- FRAME_SIZE, 256, output beats per frame; must be ≥1 and a multiple of PACKET_SIZE.
- CNT_W, 32, width of packet_count.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = new grants allowed; 0 = finish the current packet, then idle.
- axis_in1_tdata  in  DW  input stream 1 data.
- axis_in1_tvalid  in  1  input stream 1 valid.
- axis_in1_tready  out  1  input stream 1 ready.
- axis_in2_tdata  in  DW  input stream 2 data.
- axis_in2_tvalid  in  1  input stream 2 valid.
- axis_in2_tready  out  1  input stream 2 ready.
- axis_out_tdata  out  DW  merged output data (registered).
- axis_out_tvalid  out  1  output valid (registered).
- axis_out_tready  in  1  output ready.
- axis_out_tsrc  out  1  source of the current output beat: 0 = in1, 1 = in2.
- axis_out_tlast  out  1  marks the last beat of each packet.
- packet_count  out  CNT_W  completed packets; wraps modulo 2^CNT_W.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, synchronous release) clears:
  - state = IDLE, last_grant = 2, beat_cnt = 0, frame_cnt = 0;
  - axis_out_tvalid, axis_out_tlast, axis_out_tsrc, packet_count, frame_done all = 0;
  - axis_out_tdata = 0.
- Reset mid-packet abandons the packet; no partial count is retained.
- States:
  - IDLE: no input ready.
  - GNT1: only in1 may be ready.
  - GNT2: only in2 may be ready.
- Arbitration (evaluated in IDLE, and on the accepting edge of a packet's last beat):
  - If enable = 0, go to IDLE.
  - Else if both inputs are valid, grant the input opposite last_grant.
  - Else if exactly one input is valid, grant it.
  - Else go to IDLE.
  - last_grant updates when a grant is entered.
  - IDLE→GNTx costs one cycle.
  - Last beat→next GNT is zero-bubble; back-to-back packets are possible.
- Readiness:
  - axis_inX_tready = (state == GNTx) && (!axis_out_tvalid || axis_out_tready). This is combinational.
  - The ungranted input's tready = 0 always.
- Accepted beat (granted tvalid & tready):
  - Output register loads data, tsrc = x-1, tlast = (beat_cnt == PACKET_SIZE-1).
  - axis_out_tvalid <= 1.
  - beat_cnt increments, and wraps to 0 at PACKET_SIZE-1.
- Output handshake without a new accepted beat: axis_out_tvalid <= 0.
- Output stall: if axis_out_tvalid && !axis_out_tready, all output fields are held stable, tready = 0, and counters are frozen.
- Latency: input accept → output valid is 1 cycle. Sustained throughput is 1 beat/cycle with tready held high.
- Input tvalid dropping mid-packet: the scheduler stays in GNTx and waits. There is no timeout and no switching mid-packet.
- enable dropped mid-packet: the current packet completes, then IDLE.
- enable raised in IDLE: arbitration on the next edge.
- packet_count increments on each accepted last beat. It wraps from 2^CNT_W-1 to 0.
- frame_cnt counts output handshakes (axis_out_tvalid & axis_out_tready). At FRAME_SIZE-1:
  - frame_cnt wraps to 0;
  - frame_done = 1 for the following single cycle, otherwise 0.
- Because FRAME_SIZE is a multiple of PACKET_SIZE, frame boundaries coincide with tlast.
- Simultaneous frame_done and new grant: these are independent and both proceed.

Test Plan:
1. PACKET_SIZE=2, FRAME_SIZE=8, enable=1, both inputs continuously valid (in1 data 0x1.., in2 data 0x2..), out_tready=1.
   - Expected: tsrc pattern 0,0,1,1,0,0,1,1 with no bubbles after the first.
   - Expected: tlast on beats 2,4,6,8; packet_count=4 and a single frame_done pulse after the 8th handshake.
2. Only in2 valid for 6 beats.
   - Expected: three consecutive in2 packets, in1_tready always 0, packet_count=3.
   - Then assert in1: the next grant goes to in1, because last_grant=2 wins arbitration.
3. out_tready=0 for 5 cycles mid-packet.
   - Expected: tdata, tsrc and tlast held stable; both input treadys 0; counters frozen.
   - On release, data resumes with no loss or duplication (scoreboard match).
4. in1 tvalid drops after beat 1 of a packet while in2 is valid.
   - Expected: the scheduler stays in GNT1 and in2_tready=0 until in1 delivers beat 2; then it grants in2.
5. enable=0 asserted during beat 1.
   - Expected: beat 2 is still accepted with tlast=1, then IDLE with both treadys 0.
   - Re-enable: a grant follows one cycle later.
6. resetn pulsed low mid-packet, asynchronously between edges.
   - Expected: outputs go to 0 immediately (tvalid=0, packet_count=0).
   - After release, the first grant starts at beat_cnt 0 and goes to in1.

Source files
------------

// File: rtl/stream_pair_scheduler.sv
// stream_pair_scheduler: packet-granular round-robin merge of two AXI-Stream
// inputs onto one registered output stream, with packet and frame accounting.
// A grant covers PACKET_SIZE accepted beats. The next grant is chosen on the
// edge that accepts the last beat, so back-to-back packets have no bubble.
module stream_pair_scheduler #(
    parameter int DW          = 128,
    parameter int PACKET_SIZE = 2,
    parameter int FRAME_SIZE  = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [DW-1:0]    axis_in1_tdata,
    input  logic             axis_in1_tvalid,
    output logic             axis_in1_tready,
    input  logic [DW-1:0]    axis_in2_tdata,
    input  logic             axis_in2_tvalid,
    output logic             axis_in2_tready,
    output logic [DW-1:0]    axis_out_tdata,
    output logic             axis_out_tvalid,
    input  logic             axis_out_tready,
    output logic             axis_out_tsrc,
    output logic             axis_out_tlast,
    output logic [CNT_W-1:0] packet_count,
    output logic             frame_done
);

    localparam int BW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int FW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [BW-1:0] LAST_BEAT       = BW'(PACKET_SIZE - 1);
    localparam logic [FW-1:0] LAST_FRAME_BEAT = FW'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    last_grant_reg, last_grant_next;   // 1 = in1, 2 = in2
    logic [BW-1:0] beat_cnt_reg;
    logic [FW-1:0] frame_cnt_reg;

    logic out_free;
    logic accept1;
    logic accept2;
    logic accept;
    logic last_beat;
    logic out_hs;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free        = !axis_out_tvalid || axis_out_tready;
    assign axis_in1_tready = (state_reg == GNT1) && out_free;
    assign axis_in2_tready = (state_reg == GNT2) && out_free;
    assign accept1         = axis_in1_tvalid && axis_in1_tready;
    assign accept2         = axis_in2_tvalid && axis_in2_tready;
    assign accept          = accept1 || accept2;
    assign last_beat       = (beat_cnt_reg == LAST_BEAT);
    assign out_hs          = axis_out_tvalid && axis_out_tready;

    // Arbitrate when idle or when the last beat of a packet is being accepted.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        if ((state_reg == IDLE) || (accept && last_beat)) begin
            if (!enable) begin
                state_next = IDLE;
            end else if (axis_in1_tvalid && axis_in2_tvalid) begin
                if (last_grant_reg == 2'd2) begin
                    state_next      = GNT1;
                    last_grant_next = 2'd1;
                end else begin
                    state_next      = GNT2;
                    last_grant_next = 2'd2;
                end
            end else if (axis_in1_tvalid) begin
                state_next      = GNT1;
                last_grant_next = 2'd1;
            end else if (axis_in2_tvalid) begin
                state_next      = GNT2;
                last_grant_next = 2'd2;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Grant state, round-robin memory and beat position within the packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 2'd2;
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (accept) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + BW'(1);
            end
        end
    end

    // Output register: load on accept, empty on a handshake, hold while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            axis_out_tdata  <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tsrc   <= 1'b0;
            axis_out_tlast  <= 1'b0;
            packet_count    <= '0;
        end else begin
            if (accept) begin
                axis_out_tdata  <= accept2 ? axis_in2_tdata : axis_in1_tdata;
                axis_out_tsrc   <= accept2;
                axis_out_tlast  <= last_beat;
                axis_out_tvalid <= 1'b1;
                if (last_beat) begin
                    packet_count <= packet_count + CNT_W'(1);
                end
            end else if (axis_out_tready) begin
                axis_out_tvalid <= 1'b0;
            end
        end
    end

    // Frame accounting on output handshakes; frame_done pulses after the last one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_reg <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_hs) begin
                if (frame_cnt_reg == LAST_FRAME_BEAT) begin
                    frame_cnt_reg <= '0;
                    frame_done    <= 1'b1;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_pair_scheduler.sv
// Bench for stream_pair_scheduler: random stimulus against a packet-level
// reference model (ownership of the current packet, a queue of beats waiting
// at the output, and running totals for packets and frame handshakes).
module tb_stream_pair_scheduler;

    localparam int DW = 32;
    localparam int PS = 2;
    localparam int FS = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [DW-1:0] axis_in1_tdata;
    logic          axis_in1_tvalid;
    logic          axis_in1_tready;
    logic [DW-1:0] axis_in2_tdata;
    logic          axis_in2_tvalid;
    logic          axis_in2_tready;
    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          axis_out_tsrc;
    logic          axis_out_tlast;
    logic [CW-1:0] packet_count;
    logic          frame_done;

    always #5 clk = ~clk;

    stream_pair_scheduler #(
        .DW(DW), .PACKET_SIZE(PS), .FRAME_SIZE(FS), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .axis_in1_tdata(axis_in1_tdata),
        .axis_in1_tvalid(axis_in1_tvalid),
        .axis_in1_tready(axis_in1_tready),
        .axis_in2_tdata(axis_in2_tdata),
        .axis_in2_tvalid(axis_in2_tvalid),
        .axis_in2_tready(axis_in2_tready),
        .axis_out_tdata(axis_out_tdata),
        .axis_out_tvalid(axis_out_tvalid),
        .axis_out_tready(axis_out_tready),
        .axis_out_tsrc(axis_out_tsrc),
        .axis_out_tlast(axis_out_tlast),
        .packet_count(packet_count),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          src;
        logic          last;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            owner;        // 0 = nobody holds a packet, else 1 or 2
    int            beats_left;   // beats still owed by the owner
    int            last_grant;
    beat_t         exp_q[$];     // beats accepted but not yet handed downstream
    int            exp_pkt;
    int            hs_count;
    logic          exp_fd;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner      = 0;
        beats_left = 0;
        last_grant = 2;
        exp_q.delete();
        exp_pkt    = 0;
        hs_count   = 0;
        exp_fd     = 1'b0;
    endtask

    // Round-robin choice of the next packet owner.
    task automatic arbitrate(input logic en, input logic v1, input logic v2);
        int pick;
        pick = 0;
        if (en) begin
            if (v1 && v2) pick = (last_grant == 2) ? 1 : 2;
            else if (v1)  pick = 1;
            else if (v2)  pick = 2;
        end
        owner = pick;
        if (pick != 0) begin
            last_grant = pick;
            beats_left = PS;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".tvalid"}, 64'(axis_out_tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq({tag, ".tdata"}, 64'(axis_out_tdata), 64'(exp_q[0].data));
            check_eq({tag, ".tsrc"},  64'(axis_out_tsrc),  64'(exp_q[0].src));
            check_eq({tag, ".tlast"}, 64'(axis_out_tlast), 64'(exp_q[0].last));
        end
        check_eq({tag, ".packet_count"}, 64'(packet_count), 64'(exp_pkt));
        check_eq({tag, ".frame_done"},   64'(frame_done),   64'(exp_fd));
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input int p1, input int p2, input int pr, input int pe);
        logic r1, r2, a1, a2, hs, v1, v2, en, decide;
        beat_t b;
        axis_in1_tvalid = ($urandom_range(99) < p1);
        axis_in2_tvalid = ($urandom_range(99) < p2);
        axis_out_tready = ($urandom_range(99) < pr);
        enable          = ($urandom_range(99) < pe);
        axis_in1_tdata  = data1;
        axis_in2_tdata  = data2;
        #3;
        r1 = (owner == 1) && ((exp_q.size() == 0) || axis_out_tready);
        r2 = (owner == 2) && ((exp_q.size() == 0) || axis_out_tready);
        check_eq({tag, ".in1_tready"}, 64'(axis_in1_tready), 64'(r1));
        check_eq({tag, ".in2_tready"}, 64'(axis_in2_tready), 64'(r2));
        v1 = axis_in1_tvalid;
        v2 = axis_in2_tvalid;
        en = enable;
        a1 = v1 && r1;
        a2 = v2 && r2;
        hs = (exp_q.size() != 0) && axis_out_tready;
        @(posedge clk);
        #1;
        if (hs) begin
            void'(exp_q.pop_front());
            hs_count++;
        end
        exp_fd = hs && ((hs_count % FS) == 0);
        decide = (owner == 0);
        if (a1 || a2) begin
            b.data = a1 ? data1 : data2;
            b.src  = a2;
            b.last = (beats_left == 1);
            exp_q.push_back(b);
            if (a1) data1 = data1 + 1;
            else    data2 = data2 + 1;
            beats_left--;
            if (beats_left == 0) begin
                exp_pkt = (exp_pkt + 1) % (1 << CW);
                decide  = 1'b1;
            end
        end
        if (decide) arbitrate(en, v1, v2);
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n, input int p1, input int p2, input int pr, input int pe);
        for (int i = 0; i < n; i++) step(tag, p1, p2, pr, pe);
    endtask

    // Asynchronous reset pulse that lands between clock edges.
    task automatic reset_pulse(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq({tag, ".rst_tvalid"}, 64'(axis_out_tvalid), 64'(0));
        check_eq({tag, ".rst_tdata"},  64'(axis_out_tdata),  64'(0));
        check_eq({tag, ".rst_tsrc"},   64'(axis_out_tsrc),   64'(0));
        check_eq({tag, ".rst_tlast"},  64'(axis_out_tlast),  64'(0));
        check_eq({tag, ".rst_pkt"},    64'(packet_count),    64'(0));
        check_eq({tag, ".rst_fdone"},  64'(frame_done),      64'(0));
        check_eq({tag, ".rst_tready1"}, 64'(axis_in1_tready), 64'(0));
        check_eq({tag, ".rst_tready2"}, 64'(axis_in2_tready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn          = 1'b0;
        enable          = 1'b0;
        axis_in1_tvalid = 1'b0;
        axis_in2_tvalid = 1'b0;
        axis_in1_tdata  = '0;
        axis_in2_tdata  = '0;
        axis_out_tready = 1'b0;
        data1           = 32'h1000_0000;
        data2           = 32'h2000_0000;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse("init");

        // Both inputs saturated: alternating packets, first grant to in1.
        run("both_full", 12, 100, 100, 100, 100);
        // Only in2 requests, then in1 joins and must win the next grant.
        run("in2_only", 8, 0, 100, 100, 100);
        run("in1_joins", 6, 100, 100, 100, 100);
        // Downstream stall for five cycles mid-stream.
        run("pre_stall", 3, 100, 100, 100, 100);
        run("stall", 5, 100, 100, 0, 100);
        run("post_stall", 6, 100, 100, 100, 100);
        // in1 valid intermittent while in2 keeps requesting.
        run("in1_gappy", 16, 30, 100, 100, 100);
        // enable removed mid-packet, then restored.
        run("pre_disable", 3, 100, 100, 100, 100);
        run("disabled", 5, 100, 100, 100, 0);
        run("reenable", 5, 100, 100, 100, 100);
        // Reset mid-packet, then recovery.
        run("pre_reset", 3, 100, 100, 100, 100);
        reset_pulse("midpkt");
        run("post_reset", 8, 100, 100, 100, 100);

        // Randomised mixes of valid, ready and enable densities.
        for (int r = 0; r < 40; r++) begin
            int p1, p2, pr, pe;
            p1 = $urandom_range(100);
            p2 = $urandom_range(100);
            pr = $urandom_range(20, 100);
            pe = $urandom_range(50, 100);
            run("random", 50, p1, p2, pr, pe);
            if (r == 20) reset_pulse("random_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
